// File: rtl/single_port_ram_arbiter.sv
// rtl/single_port_ram_arbiter.sv - round-robin arbiter sharing one single-port RAM among NUM_REQ requesters
// Optional zero-fill sweep after reset; reads return one cycle after accept.
module single_port_ram_arbiter #(
    parameter int    NUM_REQ    = 4,
    parameter int    Dw         = 32,
    parameter int    Aw         = 10,
    parameter string BYTE_WR_EN = "YES",
    parameter string CLEAR_EN   = "YES",
    localparam int   BEw        = (BYTE_WR_EN == "YES") ? Dw / 8 : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ*Aw-1:0]  req_addr,
    input  logic [NUM_REQ*Dw-1:0]  req_data,
    input  logic [NUM_REQ*BEw-1:0] req_byteen,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [Dw-1:0]          rsp_data,
    output logic                   init_done,
    output logic [Aw-1:0]          ram_addr,
    output logic [Dw-1:0]          ram_data,
    output logic [BEw-1:0]         ram_byteen,
    output logic                   ram_we,
    input  logic [Dw-1:0]          ram_q
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [Aw-1:0]        clr_cnt_q, clr_cnt_d;
    logic [Aw-1:0]        addr_q, addr_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic [Aw-1:0]        addr_arr [NUM_REQ];
    logic [Dw-1:0]        data_arr [NUM_REQ];
    logic [BEw-1:0]       be_arr   [NUM_REQ];
    logic                 gnt_found;
    logic [PW-1:0]        gnt_idx;
    logic [PW:0]          scan_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*Aw +: Aw];
            data_arr[i] = req_data[i*Dw +: Dw];
            be_arr[i]   = req_byteen[i*BEw +: BEw];
        end
    end

    // Scan starts at rr_ptr and wraps, so the last-served requester goes to the back of the line.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PW+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[scan_idx[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        clr_cnt_d   = clr_cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = '0;
        req_ready   = '0;
        ram_we      = 1'b0;
        ram_addr    = addr_q;
        ram_data    = '0;
        ram_byteen  = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_cnt_q;
                ram_byteen = '1;
                addr_d     = clr_cnt_q;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    ram_we             = req_we[gnt_idx];
                    ram_addr           = addr_arr[gnt_idx];
                    ram_data           = data_arr[gnt_idx];
                    ram_byteen         = be_arr[gnt_idx];
                    addr_d             = addr_arr[gnt_idx];
                    rr_ptr_d           = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (!req_we[gnt_idx]) begin
                        rsp_valid_d[gnt_idx] = 1'b1;
                    end
                end
            end
        endcase
        if (reset) begin
            req_ready = '0;
            ram_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= (CLEAR_EN == "YES") ? ST_CLEAR : ST_RUN;
            rr_ptr_q    <= '0;
            clr_cnt_q   <= '0;
            addr_q      <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Read data comes straight from the RAM; only the valid strobe is registered.
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = ram_q;
    assign init_done = (state_q == ST_RUN);
endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// tb/tb_single_port_ram_arbiter.sv - self-checking bench for single_port_ram_arbiter
module tb_single_port_ram_arbiter;
    localparam int NR = 4, DW = 32, AW = 4, BEW = 4, DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR*BEW-1:0] req_byteen;
    logic [DW-1:0]     rsp_data, ram_data, ram_q;
    logic [AW-1:0]     ram_addr;
    logic [BEW-1:0]    ram_byteen;
    logic              ram_we, init_done;

    logic [AW-1:0]  a_v [NR];
    logic [DW-1:0]  d_v [NR];
    logic [BEW-1:0] b_v [NR];

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]     = a_v[i];
            req_data[i*DW +: DW]     = d_v[i];
            req_byteen[i*BEW +: BEW] = b_v[i];
        end
    end

    single_port_ram_arbiter #(.NUM_REQ(NR), .Dw(DW), .Aw(AW), .BYTE_WR_EN("YES"), .CLEAR_EN("YES")) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data), .req_byteen(req_byteen), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .init_done(init_done), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_byteen(ram_byteen), .ram_we(ram_we), .ram_q(ram_q));

    // Shared RAM: registered address, byte-enabled write; garbage while reset so the sweep matters.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] mem_addr_q;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
        end else if (ram_we) begin
            for (int b = 0; b < BEW; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
        end
        mem_addr_q <= ram_addr;
    end
    assign ram_q = mem[mem_addr_q];

    // Reference model: memory image, round-robin pointer, expected response for this/next cycle.
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_rr;
    logic [AW-1:0] last_addr;
    logic [NR-1:0] exp_v, nxt_v;
    logic [DW-1:0] exp_d, nxt_d;
    int checks = 0, errors = 0;

    function automatic int model_grant();
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(ref_rr + k) % NR]) return (ref_rr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_rr = 0; last_addr = AW'(DEPTH - 1); exp_v = '0; nxt_v = '0;
    endtask

    task automatic model_accept(input int g);
        if (g >= 0) begin
            if (req_we[g]) begin
                for (int b = 0; b < BEW; b++)
                    if (b_v[g][b]) ref_mem[a_v[g]][8*b +: 8] = d_v[g][8*b +: 8];
            end else begin
                nxt_v[g] = 1'b1;
                nxt_d    = ref_mem[a_v[g]];
            end
            last_addr = a_v[g];
            ref_rr    = (g + 1) % NR;
        end
    endtask

    task automatic next_cycle();
        exp_v = nxt_v; exp_d = nxt_d; nxt_v = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; req_we = '0;
        for (int i = 0; i < NR; i++) begin a_v[i] = '0; d_v[i] = '0; b_v[i] = '0; end
        @(negedge clk); #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_clear();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if ({ram_we, ram_addr, ram_data, ram_byteen, req_ready, init_done} !== {1'b1, AW'(i), 32'h0, 4'hF, 4'h0, 1'b0}) begin
                errors++;
                $display("FAIL clear_cycle%0d: got we=%b addr=%h data=%h be=%h rdy=%b done=%b expected we=1 addr=%h data=0 be=f rdy=0 done=0",
                         i, ram_we, ram_addr, ram_data, ram_byteen, req_ready, init_done, AW'(i));
            end
            @(negedge clk);
        end
        model_reset();
        req_valid = '0; #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL clear_done: got %b expected 1", init_done); end
        checks++; if ({ram_we, ram_addr} !== {1'b0, last_addr}) begin errors++; $display("FAIL idle_hold: got we=%b addr=%h expected we=0 addr=%h", ram_we, ram_addr, last_addr); end
        model_accept(model_grant()); next_cycle();
    endtask

    task automatic test_round_robin();
        int g;
        req_valid = '1; req_we = '0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++) a_v[i] = AW'($urandom);
            #1; g = model_grant();
            checks++; if (req_ready !== NR'(1 << (c % NR))) begin errors++; $display("FAIL rr_seq%0d: got %b expected %b", c, req_ready, NR'(1 << (c % NR))); end
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rr_rsp%0d: got %b expected %b", c, rsp_valid, exp_v); end
            model_accept(g); next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_write_read();
        int g;
        req_valid = 4'b0010; req_we = 4'b0010; a_v[1] = 4'h5; d_v[1] = 32'hA5A5A5A5; b_v[1] = 4'hF;
        #1; g = model_grant();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t3_wr_ready: got %b expected 0010", req_ready); end
        checks++; if ({ram_we, ram_addr, ram_data} !== {1'b1, 4'h5, 32'hA5A5A5A5}) begin errors++; $display("FAIL t3_wr_pins: got we=%b addr=%h data=%h expected 1/5/a5a5a5a5", ram_we, ram_addr, ram_data); end
        model_accept(g); next_cycle();
        req_valid = 4'b0100; req_we = '0; a_v[2] = 4'h5;
        #1; g = model_grant();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL t3_rd_ready: got %b expected 0100", req_ready); end
        model_accept(g); next_cycle();
        req_valid = '0; #1;
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL t3_rsp_valid: got %b expected 0100", rsp_valid); end
        checks++; if (rsp_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL t3_rsp_data: got %h expected a5a5a5a5", rsp_data); end
        model_accept(model_grant()); next_cycle();
    endtask

    task automatic test_byteen();
        req_valid = 4'b0001; req_we = 4'b0001; a_v[0] = 4'h7; d_v[0] = 32'h11223344; b_v[0] = 4'hF;
        #1; model_accept(model_grant()); next_cycle();
        d_v[0] = 32'h000000EE; b_v[0] = 4'b0001;
        #1; model_accept(model_grant()); next_cycle();
        req_we = '0;
        #1; model_accept(model_grant()); next_cycle();
        req_valid = '0; #1;
        checks++; if ({rsp_valid, rsp_data} !== {4'b0001, 32'h112233EE}) begin errors++; $display("FAIL t4_byteen: got v=%b data=%h expected 0001/112233ee", rsp_valid, rsp_data); end
        model_accept(model_grant()); next_cycle();
    endtask

    task automatic test_rr_skip();
        logic [NR-1:0] want [3];
        want[0] = 4'b0010; want[1] = 4'b1000; want[2] = 4'b0001;
        req_we = '0;
        for (int c = 0; c < 3; c++) begin
            req_valid = (c == 0) ? 4'b0010 : 4'b1001;
            for (int i = 0; i < NR; i++) a_v[i] = AW'($urandom);
            #1;
            checks++; if (req_ready !== want[c]) begin errors++; $display("FAIL t5_grant%0d: got %b expected %b", c, req_ready, want[c]); end
            checks++; if (rsp_valid !== exp_v || (exp_v != 0 && rsp_data !== exp_d)) begin errors++; $display("FAIL t5_rsp%0d: got %b/%h expected %b/%h", c, rsp_valid, rsp_data, exp_v, exp_d); end
            model_accept(model_grant()); next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        int g, max_wait;
        int wait_cnt [NR];
        logic [NR-1:0] gl;
        gl = '0; max_wait = 0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || gl[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_we[i]    = 1'($urandom_range(0, 1));
                    a_v[i]       = AW'($urandom);
                    d_v[i]       = $urandom;
                    b_v[i]       = BEW'($urandom);
                end
            end
            #1; g = model_grant();
            checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, req_ready, onehot(g)); end
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rand_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_v); end
            if (exp_v != 0) begin
                checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL rand_rsp_data c%0d: got %h expected %h", c, rsp_data, exp_d); end
            end
            if (g >= 0) begin
                checks++; if ({ram_we, ram_addr} !== {req_we[g], a_v[g]}) begin errors++; $display("FAIL rand_pins c%0d: got we=%b addr=%h expected we=%b addr=%h", c, ram_we, ram_addr, req_we[g], a_v[g]); end
                if (wait_cnt[g] > max_wait) max_wait = wait_cnt[g];
                wait_cnt[g] = 0;
            end else begin
                checks++; if ({ram_we, ram_addr} !== {1'b0, last_addr}) begin errors++; $display("FAIL rand_idle c%0d: got we=%b addr=%h expected we=0 addr=%h", c, ram_we, ram_addr, last_addr); end
            end
            for (int i = 0; i < NR; i++) if (req_valid[i] && i != g) wait_cnt[i]++;
            gl = onehot(g);
            model_accept(g); next_cycle();
        end
        checks++; if (max_wait >= NR) begin errors++; $display("FAIL starvation: got wait %0d expected below %0d", max_wait, NR); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0001; req_we = '0; a_v[0] = AW'($urandom);
        #1; model_accept(model_grant()); next_cycle();
        reset = 1'b1; req_valid = '1; #1;
        checks++; if ({req_ready, ram_we} !== 5'b0) begin errors++; $display("FAIL t6_reset_gate: got rdy=%b we=%b expected 0000/0", req_ready, ram_we); end
        @(negedge clk);
        reset = 1'b0; req_valid = '0; #1;
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL t6_rsp_dropped: got %b expected 0000", rsp_valid); end
        checks++; if ({ram_we, ram_addr, init_done} !== {1'b1, 4'h0, 1'b0}) begin errors++; $display("FAIL t6_sweep0: got we=%b addr=%h done=%b expected 1/0/0", ram_we, ram_addr, init_done); end
        @(negedge clk); #1;
        checks++; if ({ram_we, ram_addr} !== {1'b1, 4'h1}) begin errors++; $display("FAIL t6_sweep1: got we=%b addr=%h expected 1/1", ram_we, ram_addr); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_round_robin();
        test_write_read();
        test_byteen();
        test_rr_skip();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
